// File: rtl/tft_spi_streamer_if.sv
// CPU-side write port of the TFT SPI streamer: push handshake plus FIFO/engine status.
interface tft_spi_streamer_if #(
    parameter int ADDR_W = 4
);
    logic            wr_en;
    logic [8:0]      wr_data;
    logic            ovf_clr;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] level;
    logic            overflow;
    logic            busy;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  full, empty, level, overflow, busy
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output full, empty, level, overflow, busy
    );
endinterface

// File: rtl/tft_spi_streamer.sv
// Write-only SPI mode-0 master for the TFT panel: FIFO of 9-bit {D/CX, byte} entries,
// shifted out MSB first with CS held low across back-to-back entries.
module tft_spi_streamer #(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk_sys,
    input  logic              rst,
    tft_spi_streamer_if.slave bus,
    output logic              tft_SCLK,
    output logic              tft_MOSI,
    output logic              tft_CS,
    output logic              tft_D_CX
);
    localparam int              CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD
    } state_t;

    logic [8:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic [8:0]        head;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [6:0]        sr_q, sr_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_q, cs_d;
    logic              dcx_q, dcx_d;
    logic              phase_end;

    assign head      = mem_q[rd_ptr_q];
    assign phase_end = (cnt_q == CNT_LAST);

    // A drop while full beats a same-cycle ovf_clr, so the set is applied last.
    always_comb begin
        push       = bus.wr_en && !full_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
            2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);
        if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (bus.wr_en && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        dcx_d   = dcx_q;
        pop     = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                cnt_d  = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    sr_d    = head[6:0];
                    mosi_d  = head[7];
                    dcx_d   = head[8];
                    bit_d   = 3'd7;
                    cs_d    = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    sclk_d  = 1'b0;
                    state_d = SHIFT_LO;
                    // MOSI moves on at the falling edge; after bit 0 it just holds.
                    if (bit_q != 3'd0) begin
                        mosi_d = sr_q[6];
                        sr_d   = {sr_q[5:0], 1'b0};
                    end
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        sclk_d  = 1'b1;
                        state_d = SHIFT_HI;
                    end else if (!empty_q) begin
                        pop     = 1'b1;
                        sr_d    = head[6:0];
                        mosi_d  = head[7];
                        dcx_d   = head[8];
                        bit_d   = 3'd7;
                        state_d = SETUP;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    cs_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            dcx_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            dcx_q      <= dcx_d;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != IDLE);
    assign tft_SCLK     = sclk_q;
    assign tft_MOSI     = mosi_q;
    assign tft_CS       = cs_q;
    assign tft_D_CX     = dcx_q;
endmodule
